id_ex_pipe: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS pipeline, directly downstream of the decode-stage control unit.
- Captures the control bundle (reg_write, mem_to_reg, mem_write, alu_src, branch, jump, alu_op) together with decode operands, and presents them to EX one cycle later.
- Owns load-use hazard detection and drives the `stall` input of the control unit.
- Inserts bubbles on stall/flush, freezes on downstream hold, and keeps a saturating stall counter.

---
 rtl/id_ex_pipe.sv | 108 ++++++++++
 tb/tb_id_ex_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use stall detection and stall counter
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_branch,
    input  logic              id_jump,
    input  logic [2:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic [2:0]        ex_alu_op,
    output logic [5:0]        ex_funct,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_dest,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [REG_W-1:0] dest_next;
    logic             bubble;

    assign dest_next = (id_opcode == 6'b000000) ? id_rd : id_rt;

    // A load in EX whose destination is read by the ID instruction must wait one cycle.
    assign stall = ex_valid & ex_mem_to_reg & (ex_dest != '0) & id_valid &
                   ((ex_dest == id_rs) | (ex_dest == id_rt));

    assign bubble = rst | flush | (!hold & stall);

    always_ff @(posedge clk) begin
        if (bubble) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_branch     <= 1'b0;
            ex_jump       <= 1'b0;
            ex_alu_op     <= '0;
            ex_funct      <= '0;
            ex_pc4        <= '0;
            ex_rd1        <= '0;
            ex_rd2        <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_dest       <= '0;
        end else if (!hold) begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_valid & id_reg_write;
            ex_mem_to_reg <= id_valid & id_mem_to_reg;
            ex_mem_write  <= id_valid & id_mem_write;
            ex_alu_src    <= id_valid & id_alu_src;
            ex_branch     <= id_valid & id_branch;
            ex_jump       <= id_valid & id_jump;
            ex_alu_op     <= id_valid ? id_alu_op : 3'b000;
            ex_funct      <= id_funct;
            ex_pc4        <= id_pc4;
            ex_rd1        <= id_rd1;
            ex_rd2        <= id_rd2;
            ex_imm        <= id_imm;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_dest       <= dest_next;
        end
    end

    // Only stall bubbles are counted; flush and hold take precedence over a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!flush && !hold && stall && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - self-checking bench for id_ex_pipe against a behavioural slot model
module tb_id_ex_pipe;

    localparam int CNT_W = 2;
    localparam int CMAX  = 3;

    logic        clk = 1'b0;
    logic        rst, id_valid, flush, hold;
    logic [5:0]  id_opcode, id_funct;
    logic        id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src, id_branch, id_jump;
    logic [2:0]  id_alu_op;
    logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        stall, ex_valid;
    logic        ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_branch, ex_jump;
    logic [2:0]  ex_alu_op;
    logic [5:0]  ex_funct;
    logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [CNT_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    logic last_stall;

    // Reference model: contents of the EX slot as plain fields plus an integer counter.
    logic        m_valid;
    logic [5:0]  m_ctrl;
    logic [2:0]  m_alu_op;
    logic [5:0]  m_funct;
    logic [31:0] m_pc4, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_dest;
    int          m_cnt;

    id_ex_pipe #(.DATA_W(32), .REG_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op),
        .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .hold(hold),
        .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_op(ex_alu_op), .ex_funct(ex_funct),
        .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0; m_ctrl = '0; m_alu_op = '0; m_funct = '0;
        m_pc4 = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_dest = '0;
    endtask

    task automatic step();
        logic ms;
        @(negedge clk);
        ms = m_valid && m_ctrl[4] && (m_dest != 0) && id_valid &&
             (m_dest == id_rs || m_dest == id_rt);
        last_stall = stall;
        chk("stall", stall, ms);
        if (rst) begin
            model_clear();
            m_cnt = 0;
        end else if (flush) begin
            model_clear();
        end else if (!hold) begin
            if (ms) begin
                model_clear();
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            end else begin
                m_valid  = id_valid;
                m_ctrl   = id_valid ? {id_reg_write, id_mem_to_reg, id_mem_write,
                                       id_alu_src, id_branch, id_jump} : 6'b0;
                m_alu_op = id_valid ? id_alu_op : 3'b0;
                m_funct  = id_funct;
                m_pc4 = id_pc4; m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
                m_rs = id_rs; m_rt = id_rt;
                m_dest = (id_opcode == 0) ? id_rd : id_rt;
            end
        end
        @(posedge clk);
        #1;
        chk("valid_ctrl", {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write,
                           ex_alu_src, ex_branch, ex_jump}, {m_valid, m_ctrl});
        chk("alu_op", ex_alu_op, m_alu_op);
        chk("funct", ex_funct, m_funct);
        chk("pc4", ex_pc4, m_pc4);
        chk("rd1", ex_rd1, m_rd1);
        chk("rd2", ex_rd2, m_rd2);
        chk("imm", ex_imm, m_imm);
        chk("rs_rt", {ex_rs, ex_rt}, {m_rs, m_rt});
        chk("dest", ex_dest, m_dest);
        chk("stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic rand_id();
        id_valid = ($urandom_range(0, 7) != 0);
        id_opcode = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
        id_funct = 6'($urandom);
        {id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src, id_branch, id_jump} = 6'($urandom);
        id_alu_op = 3'($urandom);
        id_pc4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom_range(0, 3));
        id_rt = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
    endtask

    task automatic base(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
        rst = 0; flush = 0; hold = 0;
        rand_id();
        id_valid = 1'b1; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
        {id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src, id_branch, id_jump} = 6'b0;
        id_alu_op = 3'b000;
    endtask

    task automatic lw(input logic [4:0] rt);
        base(6'h23, 5'd1, rt, 5'd0);
        id_reg_write = 1; id_mem_to_reg = 1; id_alu_src = 1;
    endtask

    task automatic add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        base(6'h00, rs, rt, rd);
        id_funct = 6'h20; id_reg_write = 1; id_alu_op = 3'b010;
    endtask

    task automatic addi(input logic [4:0] rt, input logic [31:0] imm);
        base(6'h08, 5'd1, rt, 5'd0);
        id_imm = imm; id_reg_write = 1; id_alu_src = 1;
    endtask

    initial begin
        int exp_cnt[5] = '{1, 2, 3, 3, 3};
        model_clear();
        m_cnt = 0;
        rst = 1; flush = 0; hold = 0;
        rand_id();
        step();
        rand_id();
        step();
        chk("rst_valid", ex_valid, 0);
        chk("rst_cnt", stall_cnt, 0);

        addi(5'd5, 32'd7);
        step();
        chk("addi_rw", ex_reg_write, 1);
        chk("addi_src", ex_alu_src, 1);
        chk("addi_op", ex_alu_op, 0);
        chk("addi_dest", ex_dest, 5);
        chk("addi_imm", ex_imm, 7);

        add(5'd1, 5'd2, 5'd9);
        step();
        chk("rtype_dest", ex_dest, 9);

        lw(5'd8);
        step();
        add(5'd8, 5'd2, 5'd10);
        step();
        chk("lu_stall", last_stall, 1);
        chk("lu_bubble", {ex_valid, ex_reg_write}, 2'b00);
        chk("lu_cnt", stall_cnt, 1);
        step();
        chk("lu_stall_end", last_stall, 0);
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_dest", ex_dest, 10);

        lw(5'd0);
        step();
        add(5'd0, 5'd0, 5'd11);
        step();
        chk("zero_nostall", last_stall, 0);
        lw(5'd8);
        step();
        add(5'd3, 5'd4, 5'd12);
        step();
        chk("indep_nostall", last_stall, 0);
        chk("indep_cnt", stall_cnt, 1);

        base(6'h2b, 5'd2, 5'd3, 5'd0);
        id_mem_write = 1; id_alu_src = 1;
        flush = 1; hold = 1;
        step();
        chk("flush_valid", ex_valid, 0);
        chk("flush_mw", ex_mem_write, 0);
        addi(5'd6, 32'd99);
        step();
        for (int i = 0; i < 3; i++) begin
            rand_id();
            hold = 1;
            step();
            chk("hold_imm", ex_imm, 99);
            chk("hold_dest", ex_dest, 6);
        end

        rst = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            lw(5'd8);
            step();
            add(5'd2, 5'd8, 5'd10);
            step();
            chk("sat_cnt", stall_cnt, exp_cnt[i]);
            step();
        end

        for (int i = 0; i < 400; i++) begin
            rand_id();
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
